toy_dmem_arbiter: RTL and testbench
===================================

// Module: toy_dmem_arbiter
// PURPOSE
//   Shares the Toy CPU's single-port data memory between two requesters:
//   port 0 = CPU datapath, port 1 = DMA/IO engine.
//   Round-robin arbitration, one access in flight, registered memory command,
//   fixed-latency read return with a per-port rvalid pulse.
//   Sits between the datapath/DMA and the DataMemory instance.
// PARAMETERS
//   AW      12  address width (matches the 12-bit PC/data address)
//   DW      16  data width (matches registers A/T)
//   RD_LAT  1   cycles from the mem_rd command cycle to mem_rdata valid; legal 1..4
// PORTS
//   clk         in   1   clock, rising edge
//   reset       in   1   asynchronous, active-low (0 = reset)
//   req0/req1   in   1   access request, port 0 (CPU) / port 1 (DMA)
//   we0/we1     in   1   1 = write, 0 = read
//   addr0/addr1 in   AW  access address
//   wdata0/1    in   DW  write data
//   gnt0/gnt1   out  1   1-cycle grant pulse; the request was accepted
//   rvalid0/1   out  1   1-cycle read-data-valid pulse
//   rdata       out  DW  read data; valid only while rvalid0 or rvalid1 is high
//   mem_rd      out  1   memory read strobe
//   mem_wr      out  1   memory write strobe
//   mem_addr    out  AW  memory address
//   mem_wdata   out  DW  memory write data
//   mem_rdata   in   DW  memory read data
//   busy        out  1   high in any state other than IDLE
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE, last=1, wait counter=0.
//     All outputs 0: gnt*, rvalid*, mem_rd, mem_wr, busy, mem_addr, mem_wdata, rdata.
//     Asserting reset mid-access drops the access. No gnt or rvalid is issued for it.
//   Requester rule: hold req/we/addr/wdata stable until gnt is seen.
//     Deassert req, or present the next request, in the cycle after gnt.
//   FSM states: IDLE, ISSUE, RDWAIT. All outputs are registered.
//   IDLE:
//     Sample req0 and req1 and pick a winner:
//       - only one request -> that port wins
//       - both requests    -> the port != last wins
//     On a winner: latch we/addr/wdata, set last=winner, go to ISSUE.
//     No request: stay in IDLE.
//   ISSUE (exactly 1 cycle):
//     gnt<winner>=1; mem_addr=latched addr.
//     Write: mem_wr=1, mem_wdata=latched wdata; next state IDLE.
//     Read:  mem_rd=1; load counter=RD_LAT; next state RDWAIT.
//   RDWAIT:
//     Decrement the counter each cycle.
//     When it reaches 0 (cycle ISSUE+RD_LAT): capture mem_rdata; go to IDLE.
//     In the following cycle: rvalid<winner>=1 and rdata=captured value.
//   Timing:
//     Write: gnt at cycle N+1 (N = IDLE sampling cycle); next access can be sampled at N+2.
//     Read:  rvalid at N+2+RD_LAT.
//     Peak rate: write = 1 access / 2 cycles; read = 1 access / (2+RD_LAT) cycles.
//   rvalid cycle: the FSM is already in IDLE and may sample a new request;
//     rvalid and a new ISSUE never overlap.
//   Strobes: mem_rd and mem_wr are never high together. At most one gnt and
//     one rvalid per cycle. gnt and rvalid to the same port never coincide.
//   Held values: mem_addr, mem_wdata and rdata hold their last values when not strobed.
//   Starvation: round-robin guarantees a port waits at most one access of the other port.
//   Address width: no wrap or width conversion; addresses pass through unchanged.
// TESTING
//   1) Reset: hold reset=0 with req0=req1=1 -> all outputs 0, no gnt.
//      Release reset -> first grant goes to port 0 (last=1 at reset).
//   2) Single write: req0=1, we0=1, addr0=12'h0A5, wdata0=16'hBEEF.
//      -> gnt0 and mem_wr with addr 0A5 / data BEEF in the same cycle, 1 cycle after sampling.
//      -> busy drops the following cycle.
//   3) Read, RD_LAT=1 and RD_LAT=3: req1=1, addr1=12'h010, memory returns 16'h1234.
//      -> rvalid1=1 with rdata=16'h1234 exactly 2+RD_LAT cycles after sampling; rvalid0 stays 0.
//   4) Contention: req0 and req1 held high with 4 writes each.
//      -> grants alternate 0,1,0,1...; mem_addr always matches the granted port.
//   5) Back-to-back: port 0 reads, then writes on the cycle after rvalid0.
//      -> write ISSUE occurs 1 cycle after rvalid0; read data is not corrupted.
//   6) Reset mid-read: assert reset during RDWAIT.
//      -> no rvalid after release; state IDLE; next request is served normally.

Source files
------------

// File: rtl/toy_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : toy_dmem_arbiter
//  Description : Round-robin arbiter sharing the Toy CPU's single-port data
//                memory between the CPU datapath (port 0) and the DMA/IO
//                engine (port 1). One access in flight, registered memory
//                command, fixed-latency read return with per-port rvalid.
//  Revision    : 1.0 - initial release
// ============================================================================
module toy_dmem_arbiter #(
    parameter int AW     = 12,
    parameter int DW     = 16,
    parameter int RD_LAT = 1     // legal range 1..4
) (
    input  logic          clk,
    input  logic          reset,      // asynchronous, active-low
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    // Three bits hold the largest legal read latency (4).
    localparam int c_CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_RDWAIT = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_last;       // port that won the most recent arbitration
    logic                 w_last_nxt;
    logic                 r_win;        // port owning the access in flight
    logic                 w_win_nxt;
    logic                 r_we;         // access in flight is a write
    logic                 w_we_nxt;
    logic [c_CNT_W-1:0]   r_cnt;        // read-latency countdown
    logic [c_CNT_W-1:0]   w_cnt_nxt;

    logic                 w_gnt0_nxt;
    logic                 w_gnt1_nxt;
    logic                 w_rvalid0_nxt;
    logic                 w_rvalid1_nxt;
    logic                 w_mem_rd_nxt;
    logic                 w_mem_wr_nxt;
    logic [AW-1:0]        w_mem_addr_nxt;
    logic [DW-1:0]        w_mem_wdata_nxt;
    logic [DW-1:0]        w_rdata_nxt;
    logic                 w_busy_nxt;

    // Arbitration: a lone requester wins; on contention the port that did not
    // win last time gets the memory.
    logic                 w_pick;
    logic                 w_pick_we;
    logic [AW-1:0]        w_pick_addr;
    logic [DW-1:0]        w_pick_wdata;

    assign w_pick       = (req0 && req1) ? ~r_last : req1;
    assign w_pick_we    = w_pick ? we1    : we0;
    assign w_pick_addr  = w_pick ? addr1  : addr0;
    assign w_pick_wdata = w_pick ? wdata1 : wdata0;

    // Next-state and next-output logic; every output is registered, so the
    // values seen during a state are computed on the transition into it.
    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_win_nxt       = r_win;
        w_we_nxt        = r_we;
        w_cnt_nxt       = r_cnt;
        w_gnt0_nxt      = 1'b0;
        w_gnt1_nxt      = 1'b0;
        w_rvalid0_nxt   = 1'b0;
        w_rvalid1_nxt   = 1'b0;
        w_mem_rd_nxt    = 1'b0;
        w_mem_wr_nxt    = 1'b0;
        w_mem_addr_nxt  = mem_addr;
        w_mem_wdata_nxt = mem_wdata;
        w_rdata_nxt     = rdata;

        unique case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_state_nxt    = S_ISSUE;
                    w_last_nxt     = w_pick;
                    w_win_nxt      = w_pick;
                    w_we_nxt       = w_pick_we;
                    w_gnt0_nxt     = ~w_pick;
                    w_gnt1_nxt     = w_pick;
                    w_mem_addr_nxt = w_pick_addr;
                    w_mem_wr_nxt   = w_pick_we;
                    w_mem_rd_nxt   = ~w_pick_we;
                    if (w_pick_we) begin
                        w_mem_wdata_nxt = w_pick_wdata;
                    end
                end
            end
            S_ISSUE: begin
                if (r_we) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RDWAIT;
                    w_cnt_nxt   = c_CNT_W'(RD_LAT);
                end
            end
            S_RDWAIT: begin
                w_cnt_nxt = r_cnt - 3'd1;
                // Counter hits zero on this edge: mem_rdata is valid now.
                if (r_cnt <= 3'd1) begin
                    w_state_nxt   = S_IDLE;
                    w_rdata_nxt   = mem_rdata;
                    w_rvalid0_nxt = ~r_win;
                    w_rvalid1_nxt = r_win;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State, bookkeeping and output registers; reset drops any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_win     <= 1'b0;
            r_we      <= 1'b0;
            r_cnt     <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_win     <= w_win_nxt;
            r_we      <= w_we_nxt;
            r_cnt     <= w_cnt_nxt;
            gnt0      <= w_gnt0_nxt;
            gnt1      <= w_gnt1_nxt;
            rvalid0   <= w_rvalid0_nxt;
            rvalid1   <= w_rvalid1_nxt;
            mem_rd    <= w_mem_rd_nxt;
            mem_wr    <= w_mem_wr_nxt;
            mem_addr  <= w_mem_addr_nxt;
            mem_wdata <= w_mem_wdata_nxt;
            rdata     <= w_rdata_nxt;
            busy      <= w_busy_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_toy_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_toy_dmem_arbiter
//  Description : Self-checking bench for toy_dmem_arbiter with RD_LAT=1 and
//                RD_LAT=3 instances, a transaction-schedule reference model
//                and directed scenarios with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_toy_dmem_arbiter;

    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [15:0] wdata;
    } op_t;

    localparam int c_MAXC = 4096;

    logic        clk;
    logic        reset;
    logic        rst_next;
    logic        sel;            // 0: RD_LAT=1 instance, 1: RD_LAT=3 instance
    logic        req0, req1, we0, we1;
    logic [11:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic [15:0] mem_rdata;
    int          cyc;
    int          n_cmp;
    int          n_bad;

    // per-instance outputs
    logic        l1_gnt0, l1_gnt1, l1_rv0, l1_rv1, l1_rd, l1_wr, l1_busy;
    logic [11:0] l1_addr;
    logic [15:0] l1_wdata, l1_rdata;
    logic        l3_gnt0, l3_gnt1, l3_rv0, l3_rv1, l3_rd, l3_wr, l3_busy;
    logic [11:0] l3_addr;
    logic [15:0] l3_wdata, l3_rdata;
    logic        l1_req0, l1_req1, l3_req0, l3_req1;

    assign l1_req0 = req0 & ~sel;
    assign l1_req1 = req1 & ~sel;
    assign l3_req0 = req0 & sel;
    assign l3_req1 = req1 & sel;

    // selected instance
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_rd, mem_wr, busy;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata, rdata;
    assign gnt0      = sel ? l3_gnt0  : l1_gnt0;
    assign gnt1      = sel ? l3_gnt1  : l1_gnt1;
    assign rvalid0   = sel ? l3_rv0   : l1_rv0;
    assign rvalid1   = sel ? l3_rv1   : l1_rv1;
    assign mem_rd    = sel ? l3_rd    : l1_rd;
    assign mem_wr    = sel ? l3_wr    : l1_wr;
    assign busy      = sel ? l3_busy  : l1_busy;
    assign mem_addr  = sel ? l3_addr  : l1_addr;
    assign mem_wdata = sel ? l3_wdata : l1_wdata;
    assign rdata     = sel ? l3_rdata : l1_rdata;

    toy_dmem_arbiter #(.AW(12), .DW(16), .RD_LAT(1)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .req0(l1_req0), .req1(l1_req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(l1_gnt0), .gnt1(l1_gnt1), .rvalid0(l1_rv0), .rvalid1(l1_rv1),
        .rdata(l1_rdata), .mem_rd(l1_rd), .mem_wr(l1_wr), .mem_addr(l1_addr),
        .mem_wdata(l1_wdata), .mem_rdata(mem_rdata), .busy(l1_busy)
    );

    toy_dmem_arbiter #(.AW(12), .DW(16), .RD_LAT(3)) u_dut_l3 (
        .clk(clk), .reset(reset),
        .req0(l3_req0), .req1(l3_req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(l3_gnt0), .gnt1(l3_gnt1), .rvalid0(l3_rv0), .rvalid1(l3_rv1),
        .rdata(l3_rdata), .mem_rd(l3_rd), .mem_wr(l3_wr), .mem_addr(l3_addr),
        .mem_wdata(l3_wdata), .mem_rdata(mem_rdata), .busy(l3_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // background memory content
    function automatic logic [15:0] bg(input logic [11:0] a);
        return (a == 12'h010) ? 16'h1234 : {4'hA, a};
    endfunction

    // memory seen by the DUT: writes land at the strobe edge, reads return
    // valid data exactly RD_LAT cycles after the mem_rd cycle, junk otherwise
    logic [15:0] dmem [c_MAXC];
    bit          dwr  [c_MAXC];
    logic [16:0] pipe [3];
    logic [16:0] tap;
    always @(posedge clk) begin
        if (mem_wr) begin
            dmem[mem_addr] <= mem_wdata;
            dwr[mem_addr]  <= 1'b1;
        end
        pipe[0] <= {mem_rd, dwr[mem_addr] ? dmem[mem_addr] : bg(mem_addr)};
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end
    assign tap       = sel ? pipe[2] : pipe[0];
    assign mem_rdata = tap[16] ? tap[15:0] : 16'hDEAD;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h required %0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- reference model: schedule of expected events ----------
    bit          e_gnt0 [c_MAXC];
    bit          e_gnt1 [c_MAXC];
    bit          e_rv0  [c_MAXC];
    bit          e_rv1  [c_MAXC];
    bit          e_rd   [c_MAXC];
    bit          e_wr   [c_MAXC];
    bit          e_busy [c_MAXC];
    logic [11:0] e_addr  [c_MAXC];
    logic [15:0] e_wdata [c_MAXC];
    logic [15:0] e_rdata [c_MAXC];
    logic [15:0] m_mem [int];
    int          m_free;
    int          m_last;

    task automatic model_reset();
        for (int j = cyc + 1; j <= cyc + 8; j++) begin
            e_gnt0[j] = 0; e_gnt1[j] = 0; e_rv0[j] = 0; e_rv1[j] = 0;
            e_rd[j] = 0; e_wr[j] = 0; e_busy[j] = 0;
        end
        m_free = 0;
        m_last = 1;
    endtask

    // Inputs as they stand now are what the DUT samples at the end of cycle k.
    task automatic model_sample();
        int k, w, lat;
        logic [11:0] a;
        k   = cyc;
        lat = sel ? 3 : 1;
        if (reset && k >= m_free && (req0 || req1)) begin
            if (req0 && req1) w = (m_last == 0) ? 1 : 0;
            else              w = req1 ? 1 : 0;
            m_last = w;
            a = w ? addr1 : addr0;
            if (w == 0) e_gnt0[k+1] = 1; else e_gnt1[k+1] = 1;
            e_addr[k+1] = a;
            e_busy[k+1] = 1;
            if (w ? we1 : we0) begin
                e_wr[k+1]    = 1;
                e_wdata[k+1] = w ? wdata1 : wdata0;
                m_mem[int'(a)] = w ? wdata1 : wdata0;
                m_free = k + 2;
            end else begin
                e_rd[k+1] = 1;
                for (int j = 1; j <= lat; j++) e_busy[k+1+j] = 1;
                if (w == 0) e_rv0[k+2+lat] = 1; else e_rv1[k+2+lat] = 1;
                e_rdata[k+2+lat] = m_mem.exists(int'(a)) ? m_mem[int'(a)] : bg(a);
                m_free = k + 2 + lat;
            end
        end
    endtask

    // ---------------- per-cycle compare against the model -------------------
    logic [11:0] cur_addr;
    logic [15:0] cur_wdata, cur_rdata;
    always @(posedge clk) begin
        int c;
        #1;
        c = cyc;
        if (!reset) begin
            cur_addr = '0; cur_wdata = '0; cur_rdata = '0;
            chk("rst_strobes", {22'd0, gnt0, gnt1, rvalid0, rvalid1, mem_rd, mem_wr, busy, 3'd0}, 32'd0);
            chk("rst_addr",  32'(mem_addr),  32'd0);
            chk("rst_wdata", 32'(mem_wdata), 32'd0);
            chk("rst_rdata", 32'(rdata),     32'd0);
        end else begin
            if (e_rd[c] || e_wr[c]) cur_addr = e_addr[c];
            if (e_wr[c]) cur_wdata = e_wdata[c];
            if (e_rv0[c] || e_rv1[c]) cur_rdata = e_rdata[c];
            chk("gnt0",      32'(gnt0),    32'(e_gnt0[c]));
            chk("gnt1",      32'(gnt1),    32'(e_gnt1[c]));
            chk("rvalid0",   32'(rvalid0), 32'(e_rv0[c]));
            chk("rvalid1",   32'(rvalid1), 32'(e_rv1[c]));
            chk("mem_rd",    32'(mem_rd),  32'(e_rd[c]));
            chk("mem_wr",    32'(mem_wr),  32'(e_wr[c]));
            chk("busy",      32'(busy),    32'(e_busy[c]));
            chk("mem_addr",  32'(mem_addr),  32'(cur_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(cur_wdata));
            chk("rdata",     32'(rdata),     32'(cur_rdata));
        end
    end

    // ---------------- requesters and stimulus helpers ------------------------
    op_t q0[$];
    op_t q1[$];
    logic        o_g0, o_g1, o_rv0, o_rv1, o_wr, o_busy;
    logic [11:0] o_addr;
    logic [15:0] o_wdata, o_rdata;

    task automatic tick();
        @(negedge clk);
        o_g0 = gnt0; o_g1 = gnt1; o_rv0 = rvalid0; o_rv1 = rvalid1;
        o_wr = mem_wr; o_busy = busy; o_addr = mem_addr;
        o_wdata = mem_wdata; o_rdata = rdata;
        if (rst_next != reset) begin
            reset = rst_next;
            if (!rst_next) model_reset();
        end
        if (req0 && o_g0) void'(q0.pop_front());
        if (req1 && o_g1) void'(q1.pop_front());
        if (q0.size() > 0) begin
            req0 = 1'b1; we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].wdata;
        end else req0 = 1'b0;
        if (q1.size() > 0) begin
            req1 = 1'b1; we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].wdata;
        end else req1 = 1'b0;
        model_sample();
    endtask

    task automatic wait_gnt(output int port, output int at);
        port = -1; at = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (o_g0 || o_g1) begin
                port = o_g1 ? 1 : 0;
                at   = cyc;
                return;
            end
        end
        chk("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rv(output int port, output logic [15:0] data, output int at);
        port = -1; at = -1; data = '0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (o_rv0 || o_rv1) begin
                port = o_rv1 ? 1 : 0;
                data = o_rdata;
                at   = cyc;
                return;
            end
        end
        chk("rvalid_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int idle_run;
        idle_run = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (q0.size() == 0 && q1.size() == 0 && !o_busy && !req0 && !req1) idle_run++;
            else idle_run = 0;
            if (idle_run >= 3) return;
        end
        chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_suite();
        int p, at, s, rv_at, n;
        logic [15:0] d;

        // 1) reset held with both requests pending; first grant to port 0
        rst_next = 1'b0;
        tick();
        q0.push_back('{1'b1, 12'h001, 16'h0101});
        q1.push_back('{1'b1, 12'h002, 16'h0202});
        for (int i = 0; i < 4; i++) tick();
        chk("t1_no_gnt_in_reset", 32'(o_g0 | o_g1), 32'd0);
        rst_next = 1'b1;
        wait_gnt(p, at);
        chk("t1_first_port", 32'(p), 32'd0);
        wait_gnt(p, at);
        chk("t1_second_port", 32'(p), 32'd1);
        drain();

        // 2) single write
        q0.push_back('{1'b1, 12'h0A5, 16'hBEEF});
        tick();
        s = cyc;
        wait_gnt(p, at);
        chk("t2_port", 32'(p), 32'd0);
        chk("t2_gnt_cycle", 32'(at), 32'(s + 1));
        chk("t2_mem_wr", 32'(o_wr), 32'd1);
        chk("t2_addr", 32'(o_addr), 32'h0A5);
        chk("t2_wdata", 32'(o_wdata), 32'hBEEF);
        tick();
        chk("t2_busy_drop", 32'(o_busy), 32'd0);
        drain();

        // 3) read on port 1
        q1.push_back('{1'b0, 12'h010, 16'h0000});
        tick();
        s = cyc;
        wait_rv(p, d, at);
        chk("t3_rv_port", 32'(p), 32'd1);
        chk("t3_rdata", 32'(d), 32'h1234);
        chk("t3_rv_cycle", 32'(at), 32'(s + (sel ? 5 : 3)));
        drain();

        // 4) contention: four writes each, grants alternate
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{1'b1, 12'h100 + 12'(i), 16'h1000 + 16'(i)});
            q1.push_back('{1'b1, 12'h200 + 12'(i), 16'h2000 + 16'(i)});
        end
        for (int i = 0; i < 8; i++) begin
            wait_gnt(p, at);
            chk("t4_port", 32'(p), 32'(i % 2));
            chk("t4_addr", 32'(o_addr), 32'((i % 2 == 0) ? 12'h100 : 12'h200) + 32'(i / 2));
        end
        drain();

        // 5) port 0 read then write right after rvalid0
        q0.push_back('{1'b0, 12'h0A5, 16'h0000});
        q0.push_back('{1'b1, 12'h0A5, 16'h5555});
        wait_rv(p, d, rv_at);
        chk("t5_rv_port", 32'(p), 32'd0);
        chk("t5_rdata", 32'(d), 32'hBEEF);
        wait_gnt(p, at);
        chk("t5_wr_cycle", 32'(at), 32'(rv_at + 1));
        chk("t5_wr_strobe", 32'(o_wr), 32'd1);
        drain();

        // 6) reset during RDWAIT drops the read
        q1.push_back('{1'b0, 12'h020, 16'h0000});
        wait_gnt(p, at);
        rst_next = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) tick();
        rst_next = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_rv0 || o_rv1) n++;
        end
        chk("t6_no_rvalid", 32'(n), 32'd0);
        chk("t6_idle", 32'(o_busy), 32'd0);
        q0.push_back('{1'b1, 12'h030, 16'h7777});
        q0.push_back('{1'b0, 12'h030, 16'h0000});
        wait_rv(p, d, at);
        chk("t6_after_port", 32'(p), 32'd0);
        chk("t6_after_rdata", 32'(d), 32'h7777);
        drain();
    endtask

    initial begin
        reset = 1'b0; rst_next = 1'b0; sel = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        cyc = 0; n_cmp = 0; n_bad = 0;
        m_free = 0; m_last = 1;
        run_suite();
        rst_next = 1'b0;
        tick();
        sel = 1'b1;
        run_suite();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
